// File: rtl/fir_sym_mc.sv
`timescale 1ns/1ps
// Multi-channel symmetric even-length FIR: one shared pre-add/multiply/accumulate term per
// cycle, a circular sample history per channel, and coefficients writable while idle.
module fir_sym_mc #(
   parameter int DATA_W    = 8,
   parameter int COEF_W    = 8,
   parameter int HALF_TAPS = 11,
   parameter int NUM_CH    = 2,
   parameter int CH_W      = 1,
   parameter int ADDR_W    = 4,
   parameter int OUT_W     = 20
) (
   input  logic              CLK_Filter,
   input  logic              rst_n,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [CH_W-1:0]   in_ch,
   input  logic [DATA_W-1:0] in_data,
   input  logic              coef_we,
   input  logic [ADDR_W-1:0] coef_addr,
   input  logic [COEF_W-1:0] coef_data,
   output logic              out_valid,
   output logic [CH_W-1:0]   out_ch,
   output logic [OUT_W-1:0]  out_data,
   output logic              out_sat
);

   localparam int TAPS   = 2 * HALF_TAPS;
   localparam int IDX_W  = $clog2(TAPS);
   localparam int PRE_W  = DATA_W + 1;
   localparam int PROD_W = DATA_W + COEF_W + 1;
   localparam int ACC_W  = PROD_W + $clog2(HALF_TAPS);

   localparam logic [IDX_W:0]    TAPS_X   = (IDX_W + 1)'(TAPS);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(TAPS - 1);
   localparam logic [ADDR_W-1:0] K_LAST   = ADDR_W'(HALF_TAPS - 1);
   localparam logic [CH_W:0]     NUM_CH_X = (CH_W + 1)'(NUM_CH);
   localparam logic [ADDR_W:0]   HT_X     = (ADDR_W + 1)'(HALF_TAPS);
   localparam logic [ACC_W-1:0]  SAT_LIM  = ACC_W'({OUT_W{1'b1}});

   // Handshake: a sample transfers on a rising edge where in_valid && in_ready; in_ready is
   // high only in IDLE, so a busy block leaves the source holding its sample unchanged.
   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_MAC  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t state, state_nx;

   logic [DATA_W-1:0] hist [NUM_CH][TAPS];
   logic [IDX_W-1:0]  wp   [NUM_CH];
   logic [COEF_W-1:0] coef [HALF_TAPS];

   logic [CH_W-1:0]   ch_q;
   logic [IDX_W-1:0]  base_q;
   logic [ADDR_W-1:0] k_q;
   logic [ACC_W-1:0]  acc_q;

   logic              ch_ok;
   logic              addr_ok;
   logic              take;
   logic [IDX_W-1:0]  off_near;
   logic [IDX_W-1:0]  off_far;
   logic [IDX_W-1:0]  idx_near;
   logic [IDX_W-1:0]  idx_far;
   logic [DATA_W-1:0] x_near;
   logic [DATA_W-1:0] x_far;
   logic [PRE_W-1:0]  pre_sum;
   logic [PROD_W-1:0] prod;
   logic              acc_over;

   function automatic logic [COEF_W-1:0] default_coef(input int i);
      int v;
      case (i)
         0:       v = 2;
         1:       v = 10;
         2:       v = 16;
         3:       v = 28;
         4:       v = 43;
         5:       v = 60;
         6:       v = 78;
         7:       v = 95;
         8:       v = 111;
         9:       v = 122;
         10:      v = 128;
         default: v = 0;
      endcase
      return COEF_W'(v);
   endfunction

   // Position of x[n-off] in a circular history whose newest sample sits at base.
   function automatic logic [IDX_W-1:0] back_idx(input logic [IDX_W-1:0] base,
                                                 input logic [IDX_W-1:0] off);
      logic [IDX_W:0] t;
      t = {1'b0, base} + TAPS_X - {1'b0, off};
      if (t >= TAPS_X) t = t - TAPS_X;
      return t[IDX_W-1:0];
   endfunction

   assign ch_ok   = ({1'b0, in_ch} < NUM_CH_X);
   assign addr_ok = ({1'b0, coef_addr} < HT_X);
   assign take    = in_valid & in_ready & ch_ok;

   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nx;
   end

   always_comb begin
      state_nx = state;
      in_ready = 1'b0;
      case (state)
         S_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && ch_ok) state_nx = S_MAC;
         end
         S_MAC: begin
            if (k_q == K_LAST) state_nx = S_DONE;
         end
         S_DONE: begin
            state_nx = S_IDLE;
         end
         default: begin
            state_nx = S_IDLE;
         end
      endcase
   end

   // Tap pair k combines x[n-k] with its mirror x[n-(TAPS-1-k)].
   always_comb begin
      off_near = IDX_W'(k_q);
      off_far  = LAST_IDX - off_near;
      idx_near = back_idx(base_q, off_near);
      idx_far  = back_idx(base_q, off_far);
      x_near   = hist[ch_q][idx_near];
      x_far    = hist[ch_q][idx_far];
      pre_sum  = {1'b0, x_near} + {1'b0, x_far};
      prod     = PROD_W'(pre_sum) * PROD_W'(coef[k_q]);
      acc_over = (acc_q > SAT_LIM);
   end

   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) begin
         for (int c = 0; c < NUM_CH; c++) begin
            wp[c] <= '0;
            for (int t = 0; t < TAPS; t++) hist[c][t] <= '0;
         end
      end else if (take) begin
         hist[in_ch][wp[in_ch]] <= in_data;
         wp[in_ch]              <= (wp[in_ch] == LAST_IDX) ? '0 : wp[in_ch] + 1'b1;
      end
   end

   // Written on the accepting edge, so a sample taken in the same cycle sees the new value.
   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < HALF_TAPS; i++) coef[i] <= default_coef(i);
      end else if ((state == S_IDLE) && coef_we && addr_ok) begin
         coef[coef_addr] <= coef_data;
      end
   end

   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) begin
         ch_q   <= '0;
         base_q <= '0;
         k_q    <= '0;
         acc_q  <= '0;
      end else begin
         case (state)
            S_IDLE: begin
               if (take) begin
                  ch_q   <= in_ch;
                  base_q <= wp[in_ch];
                  k_q    <= '0;
                  acc_q  <= '0;
               end
            end
            S_MAC: begin
               acc_q <= acc_q + ACC_W'(prod);
               k_q   <= k_q + 1'b1;
            end
            default: begin
            end
         endcase
      end
   end

   always_ff @(posedge CLK_Filter or negedge rst_n) begin
      if (!rst_n) begin
         out_valid <= 1'b0;
         out_ch    <= '0;
         out_data  <= '0;
         out_sat   <= 1'b0;
      end else begin
         out_valid <= 1'b0;
         if (state == S_DONE) begin
            out_valid <= 1'b1;
            out_ch    <= ch_q;
            out_data  <= acc_over ? {OUT_W{1'b1}} : OUT_W'(acc_q);
            out_sat   <= acc_over;
         end
      end
   end

endmodule

// File: tb/tb_fir_sym_mc.sv
`timescale 1ns/1ps
// Bench for fir_sym_mc: impulse table, channel interleave, handshake timing, coefficient
// writes, saturation and mid-computation reset, checked against a direct-convolution model.
module tb_fir_sym_mc;

   localparam int HT      = 11;
   localparam int TAPS    = 2 * HT;
   localparam int OUT_MAX = 1048575;
   localparam int LAT     = 13;

   logic        CLK_Filter = 1'b0;
   logic        rst_n      = 1'b0;
   logic        in_valid   = 1'b0;
   logic        in_ready;
   logic [0:0]  in_ch      = '0;
   logic [7:0]  in_data    = '0;
   logic        coef_we    = 1'b0;
   logic [3:0]  coef_addr  = '0;
   logic [7:0]  coef_data  = '0;
   logic        out_valid;
   logic [0:0]  out_ch;
   logic [19:0] out_data;
   logic        out_sat;

   fir_sym_mc dut (
      .CLK_Filter (CLK_Filter),
      .rst_n      (rst_n),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_ch      (in_ch),
      .in_data    (in_data),
      .coef_we    (coef_we),
      .coef_addr  (coef_addr),
      .coef_data  (coef_data),
      .out_valid  (out_valid),
      .out_ch     (out_ch),
      .out_data   (out_data),
      .out_sat    (out_sat)
   );

   always #5 CLK_Filter = ~CLK_Filter;

   typedef struct {
      int ch;
      int data;
      int exp_data;
      int exp_sat;
   } vec_t;

   vec_t        tbl [23];
   int          dflt [HT] = '{2, 10, 16, 28, 43, 60, 78, 95, 111, 122, 128};
   int          coef_m [HT];
   int          hist_m [2][TAPS];
   int          wp_m [2];
   logic [21:0] exp_q [$];
   int          lat_q [$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          gap_chk  = 0;
   int          last_acc = -1;
   int          last_out [2];
   int          last_sat [2];
   logic [21:0] mon_e;
   int          mon_a;

   task automatic chk(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s actual=%0d expected=%0d (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic fail(input string name);
      n_checks++;
      n_fail++;
      $display("FAIL %s actual=event expected=none (t=%0t)", name, $time);
   endtask

   task automatic model_reset();
      for (int c = 0; c < 2; c++) begin
         wp_m[c] = 0;
         for (int t = 0; t < TAPS; t++) hist_m[c][t] = 0;
      end
      for (int i = 0; i < HT; i++) coef_m[i] = dflt[i];
   endtask

   // Full 22-tap convolution with the mirrored coefficient set.
   task automatic model_push(input int ch, input int d, output int e, output int s);
      longint acc;
      int h;
      int idx;
      hist_m[ch][wp_m[ch]] = d;
      acc = 0;
      for (int j = 0; j < TAPS; j++) begin
         h   = (j < HT) ? coef_m[j] : coef_m[TAPS - 1 - j];
         idx = (wp_m[ch] - j + TAPS) % TAPS;
         acc += longint'(h) * longint'(hist_m[ch][idx]);
      end
      wp_m[ch] = (wp_m[ch] + 1) % TAPS;
      s = (acc > OUT_MAX) ? 1 : 0;
      e = (s != 0) ? OUT_MAX : int'(acc);
   endtask

   task automatic push_exp(input int ch, input int d, input int s);
      exp_q.push_back({1'(ch), 1'(s), 20'(d)});
   endtask

   task automatic drive(input int ch, input int d);
      int ok;
      in_valid = 1'b1;
      in_ch    = 1'(ch);
      in_data  = 8'(d);
      ok = 0;
      for (int t = 0; t < 100; t++) begin
         @(negedge CLK_Filter);
         if (in_ready) begin
            ok = 1;
            break;
         end
      end
      if (ok == 0) fail("in_ready_timeout");
      @(posedge CLK_Filter);
      #1;
   endtask

   task automatic send(input int ch, input int d);
      int e;
      int s;
      model_push(ch, d, e, s);
      push_exp(ch, e, s);
      drive(ch, d);
   endtask

   task automatic send_exp(input int ch, input int d, input int ed, input int es);
      int e;
      int s;
      model_push(ch, d, e, s);
      push_exp(ch, ed, es);
      drive(ch, d);
   endtask

   task automatic idle();
      in_valid = 1'b0;
   endtask

   task automatic drain();
      for (int i = 0; i < 400 && exp_q.size() != 0; i++) @(posedge CLK_Filter);
      if (exp_q.size() != 0) begin
         fail("drain_timeout");
         exp_q.delete();
         lat_q.delete();
      end
      @(posedge CLK_Filter);
      #1;
   endtask

   task automatic coef_write(input int a, input int d);
      coef_we   = 1'b1;
      coef_addr = 4'(a);
      coef_data = 8'(d);
      @(posedge CLK_Filter);
      #1;
      coef_we = 1'b0;
      if (a < HT) coef_m[a] = d;
   endtask

   always @(posedge CLK_Filter) cyc++;

   // Scoreboard: outputs popped against expectations, accepts timed against outputs.
   always @(negedge CLK_Filter) begin
      if (rst_n && in_valid && in_ready) begin
         lat_q.push_back(cyc);
         if (gap_chk != 0) begin
            if (last_acc >= 0) chk("accept_gap", cyc - last_acc, LAT);
            last_acc = cyc;
         end
      end
      if (out_valid) begin
         if (exp_q.size() == 0) begin
            fail("unexpected_out_valid");
         end else begin
            mon_e = exp_q.pop_front();
            chk("out_ch", out_ch, mon_e[21]);
            chk("out_data", out_data, mon_e[19:0]);
            chk("out_sat", out_sat, mon_e[20]);
            last_out[out_ch] = out_data;
            last_sat[out_ch] = out_sat;
         end
         if (lat_q.size() != 0) begin
            mon_a = lat_q.pop_front();
            chk("latency", cyc - mon_a, LAT);
         end
      end
   end

   initial begin
      tbl[0] = '{0, 255, 2 * 255, 0};
      for (int i = 1; i < TAPS; i++)
         tbl[i] = '{0, 0, ((i < HT) ? dflt[i] : dflt[TAPS - 1 - i]) * 255, 0};
      tbl[22] = '{0, 0, 0, 0};
      model_reset();

      // Reset state
      repeat (3) @(posedge CLK_Filter);
      @(negedge CLK_Filter);
      rst_n = 1'b1;
      @(negedge CLK_Filter);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_out_sat", out_sat, 0);
      chk("rst_out_ch", out_ch, 0);
      chk("rst_in_ready", in_ready, 1);
      @(posedge CLK_Filter);
      #1;

      // Impulse response on channel 0
      for (int i = 0; i < 23; i++)
         send_exp(tbl[i].ch, tbl[i].data, tbl[i].exp_data, tbl[i].exp_sat);
      idle();
      drain();

      // Interleave DC on channel 1 with zeros on channel 0; a busy coef write must be ignored
      for (int i = 0; i < TAPS; i++) begin
         send(1, 255);
         send(0, 0);
         if (i == 5) begin
            coef_write(0, 0);
            coef_m[0] = dflt[0];
         end
      end
      idle();
      drain();
      chk("ch1_dc_settled", last_out[1], 353430);
      chk("ch0_stays_zero", last_out[0], 0);

      // Valid held high: fixed accept spacing and latency
      gap_chk  = 1;
      last_acc = -1;
      for (int i = 0; i < 6; i++) send(i % 2, $urandom_range(1, 255));
      idle();
      drain();
      gap_chk = 0;

      // Random interleaved traffic
      for (int i = 0; i < 16; i++) send($urandom_range(0, 1), $urandom_range(1, 255));
      idle();
      drain();

      // Coefficient write in the same cycle as a sample accept
      coef_m[10] = 200;
      coef_we    = 1'b1;
      coef_addr  = 4'd10;
      coef_data  = 8'd200;
      send(1, 77);
      coef_we = 1'b0;
      idle();
      drain();

      // Saturation with all coefficients at full scale; out-of-range address ignored
      for (int a = 0; a < HT; a++) coef_write(a, 255);
      coef_write(12, 7);
      for (int i = 0; i < TAPS; i++) send(0, 255);
      idle();
      drain();
      chk("sat_out_data", last_out[0], OUT_MAX);
      chk("sat_flag", last_sat[0], 1);

      // Reset in the middle of a computation
      send(0, 50);
      repeat (5) @(posedge CLK_Filter);
      #1;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      exp_q.delete();
      lat_q.delete();
      model_reset();
      repeat (2) @(negedge CLK_Filter);
      chk("abort_out_valid", out_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_out_data", out_data, 0);
      rst_n = 1'b1;
      @(posedge CLK_Filter);
      #1;
      send_exp(0, 100, 200, 0);
      idle();
      drain();
      repeat (20) @(posedge CLK_Filter);
      #1;

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
